mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 128-bit memory port between the instruction-cache and data-cache wrappers.
//  Latches one client's read/write block request and forwards it to memory as a registered request.
//  Routes mem_ready back to the granted client only.
//  Sits between the icache/dcache wrappers and the memory model. The default policy gives
//  dcache priority, with a starvation guard for icache.
// PARAMETERS
//  ADDR_W        28   block address width (word address >> 2)
//  DATA_W        128  block data width
//  STARVE_LIMIT  4    consecutive dcache grants while icache waits before icache is forced next (1..15)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  i_read       in   1       icache block read request
//  i_write      in   1       icache block write request
//  i_addr       in   ADDR_W  icache block address
//  i_wdata      in   DATA_W  icache write data
//  i_ready      out  1       icache transaction complete (1 cycle)
//  d_read       in   1       dcache block read request
//  d_write      in   1       dcache block write request
//  d_addr       in   ADDR_W  dcache block address
//  d_wdata      in   DATA_W  dcache write data
//  d_ready      out  1       dcache transaction complete (1 cycle)
//  c_rdata      out  DATA_W  mem_rdata broadcast to both clients (combinational)
//  mem_read     out  1       registered read request to memory
//  mem_write    out  1       registered write request to memory
//  mem_addr     out  ADDR_W  registered address
//  mem_wdata    out  DATA_W  registered write data
//  mem_rdata    in   DATA_W  memory read data
//  mem_ready    in   1       memory completion pulse
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; mem_read=mem_write=0; mem_addr=0; mem_wdata=0;
//    i_ready=d_ready=0; starve_cnt=0.
//  - Request definitions: req_i = i_read|i_write; req_d = d_read|d_write.
//    Clients hold the request and operands stable until their ready pulse.
//  - FSM states and transitions:
//    IDLE -> GNT_D if req_d and !(req_i and starve_cnt==STARVE_LIMIT).
//    IDLE -> GNT_I if req_i and not going to GNT_D.
//    On the IDLE->GNT_x edge, the chosen client's read/write/addr/wdata are registered
//    onto mem_*. If a client asserts read and write together, only mem_write is issued.
//    GNT_x: mem_* held constant. x_ready = mem_ready combinationally; other client's ready=0.
//    On mem_ready: mem_read/mem_write clear at the next edge, and the state returns to IDLE
//    (one bubble cycle minimum between transactions).
//  - Latency: request seen in cycle N (IDLE) -> mem_read/write high in N+1.
//    mem_ready in cycle M -> x_ready in M -> mem_* low in M+1.
//  - mem_ready while IDLE is ignored; no ready is forwarded.
//  - A client dropping its request while granted is a protocol violation.
//    The grant is held until mem_ready regardless.
//  - starve_cnt (4-bit): +1 on each GNT_D entry while req_i=1, saturating at STARVE_LIMIT.
//    Cleared on GNT_I entry, or on GNT_D entry with req_i=0.
//  - Simultaneous new requests from both clients in IDLE follow the priority rule above.
//    The losing request waits and no data is lost.
//  - Reset mid-transaction abandons it. Memory must be reset with the arbiter.
// CONFIGURATION
//  MEM_ARB_STAT_EN defined: adds outputs
//    i_grant_count[31:0], d_grant_count[31:0], i_wait_cycles[31:0], d_wait_cycles[31:0].
//    Grant counts increment on GNT_x entry.
//    Wait cycles increment each cycle req_x=1 and the client is not granted.
//    All four reset to 0 and wrap at 2^32.
//  MEM_ARB_STAT_EN undefined: these ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. Single icache read, addr=0x0000123, memory ready after 3 cycles ->
//     mem_read=1 one cycle after request, mem_addr=0x0000123, i_ready pulses once,
//     d_ready stays 0, mem_read low the cycle after.
//  2. Both request in the same IDLE cycle (d_write addr 0x40, i_read addr 0x80) ->
//     dcache write issued first with mem_wdata=d_wdata, then icache read after one bubble.
//  3. dcache requests back-to-back while icache waits, STARVE_LIMIT=4 ->
//     exactly 4 dcache grants, then icache granted, then dcache resumes.
//  4. rst_n pulled low during GNT_D with mem_write=1 -> all outputs 0 immediately;
//     after release, state is IDLE and a pending request is re-granted.
//  5. mem_ready pulsed while IDLE with no requests -> i_ready=d_ready=0 and no state change.
//  6. MEM_ARB_STAT_EN: run scenario 2 -> i_grant_count=1, d_grant_count=1,
//     i_wait_cycles equals the dcache transaction length plus 1.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Client/memory bundle for mem_port_arbiter.
// The arbiter uses the slave modport: it serves the two cache clients and
// drives the registered memory request. The master modport is the mirror
// view, for whatever sits on the other side (the caches and the memory model).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  // icache client
  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_ready;
  // dcache client
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  // shared read data back to both clients
  logic [DATA_W-1:0] c_rdata;
  // memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    input  d_read, d_write, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_ready, d_ready, c_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    output d_read, d_write, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_ready, d_ready, c_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block-wide memory port between icache and dcache.
// dcache wins by default; after STARVE_LIMIT consecutive dcache grants taken
// while icache was waiting, icache is forced onto the port next.
// One request is in flight at a time; every transaction is followed by at
// least one IDLE bubble cycle before the next grant.
// Optional build macro MEM_ARB_STAT_EN adds grant and wait-cycle counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STAT_EN
  ,
  output logic [31:0]       i_grant_count,
  output logic [31:0]       d_grant_count,
  output logic [31:0]       i_wait_cycles,
  output logic [31:0]       d_wait_cycles
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        starve_q, starve_d;

  logic req_i, req_d, pick_d;

  assign req_i  = bus.i_read | bus.i_write;
  assign req_d  = bus.d_read | bus.d_write;
  // dcache takes the port unless icache is waiting and has been starved long enough
  assign pick_d = req_d && !(req_i && (starve_q == LIMIT));

  // State and registered memory request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      starve_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      starve_q    <= starve_d;
    end
  end

  // Grant decision in IDLE, hold while granted, release on mem_ready
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    starve_d    = starve_q;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = GNT_D;
          // read+write together issues only the write
          mem_write_d = bus.d_write;
          mem_read_d  = bus.d_read & ~bus.d_write;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          if (!req_i)
            starve_d = 4'd0;
          else if (starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
        end else if (req_i) begin
          state_d     = GNT_I;
          mem_write_d = bus.i_write;
          mem_read_d  = bus.i_read & ~bus.i_write;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = bus.i_wdata;
          starve_d    = 4'd0;
        end
      end
      GNT_I, GNT_D: begin
        // grant is held until memory completes, even if the client drops its request
        if (bus.mem_ready) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // Completion is steered only to the granted client; mem_ready in IDLE is dropped
  assign bus.i_ready   = (state_q == GNT_I) && bus.mem_ready;
  assign bus.d_ready   = (state_q == GNT_D) && bus.mem_ready;
  assign bus.c_rdata   = bus.mem_rdata;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_STAT_EN
  logic [31:0] i_gnt_q, d_gnt_q, i_wait_q, d_wait_q;
  logic        enter_i, enter_d;

  assign enter_i = (state_q == IDLE) && (state_d == GNT_I);
  assign enter_d = (state_q == IDLE) && (state_d == GNT_D);

  // A client is waiting while it requests and neither holds nor is being given the port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_gnt_q  <= '0;
      d_gnt_q  <= '0;
      i_wait_q <= '0;
      d_wait_q <= '0;
    end else begin
      if (enter_i) i_gnt_q <= i_gnt_q + 32'd1;
      if (enter_d) d_gnt_q <= d_gnt_q + 32'd1;
      if (req_i && (state_q != GNT_I) && !enter_i) i_wait_q <= i_wait_q + 32'd1;
      if (req_d && (state_q != GNT_D) && !enter_d) d_wait_q <= d_wait_q + 32'd1;
    end
  end

  assign i_grant_count = i_gnt_q;
  assign d_grant_count = d_gnt_q;
  assign i_wait_cycles = i_wait_q;
  assign d_wait_cycles = d_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a random phase.
// The reference model works at transaction level: it tracks which client owns
// the port, the run of dcache wins while icache waits, and the memory latency,
// and from that predicts every cycle's memory request and ready pulses.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int LIMIT  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_STAT_EN
  logic [31:0] i_grant_count, d_grant_count, i_wait_cycles, d_wait_cycles;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ARB_STAT_EN
    ,
    .i_grant_count (i_grant_count),
    .d_grant_count (d_grant_count),
    .i_wait_cycles (i_wait_cycles),
    .d_wait_cycles (d_wait_cycles)
`endif
  );

  typedef struct {
    bit                act;
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } client_t;

  int      vectors     = 0;
  int      miscompares = 0;
  client_t cl [2];          // 0 = icache, 1 = dcache
  int      owner   = -1;    // client holding the port this cycle, -1 = none
  int      streak  = 0;     // dcache wins in a row while icache waited
  int      memcnt  = 0;     // cycles left before memory completes
  int      mem_lat = -1;    // fixed memory latency, -1 = random
  int      spur    = 0;     // idle mem_ready: 0 never, 1 random, 2 always
  int      gen_pct [2];
  int      ready_seen [2];
  int      grants [$];
  int      exp3 [6] = '{1, 1, 1, 1, 0, 1};

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic client_t new_req();
    client_t c;
    int op;
    op      = int'($urandom_range(0, 3));
    c.act   = 1'b1;
    c.rd    = (op != 1);
    c.wr    = (op == 1) || (op == 2);
    c.addr  = ADDR_W'($urandom);
    c.wdata = {$urandom, $urandom, $urandom, $urandom};
    return c;
  endfunction

  task automatic drive();
    bus.i_read    = cl[0].act & cl[0].rd;
    bus.i_write   = cl[0].act & cl[0].wr;
    bus.i_addr    = cl[0].addr;
    bus.i_wdata   = cl[0].wdata;
    bus.d_read    = cl[1].act & cl[1].rd;
    bus.d_write   = cl[1].act & cl[1].wr;
    bus.d_addr    = cl[1].addr;
    bus.d_wdata   = cl[1].wdata;
    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (owner >= 0)     bus.mem_ready = (memcnt == 0);
    else if (spur == 2) bus.mem_ready = 1'b1;
    else if (spur == 1) bus.mem_ready = ($urandom_range(0, 3) == 0);
    else                bus.mem_ready = 1'b0;
  endtask

  task automatic check_cycle();
    logic er, ew;
    chk("c_rdata", bus.c_rdata, bus.mem_rdata);
    if (owner < 0) begin
      chk("mem_read_idle",  bus.mem_read,  0);
      chk("mem_write_idle", bus.mem_write, 0);
      chk("i_ready_idle",   bus.i_ready,   0);
      chk("d_ready_idle",   bus.d_ready,   0);
    end else begin
      ew = cl[owner].wr;
      er = cl[owner].rd && !ew;
      chk("mem_read",  bus.mem_read,  er);
      chk("mem_write", bus.mem_write, ew);
      chk("mem_addr",  bus.mem_addr,  cl[owner].addr);
      chk("mem_wdata", bus.mem_wdata, cl[owner].wdata);
      chk("i_ready",   bus.i_ready,   (owner == 0) && bus.mem_ready);
      chk("d_ready",   bus.d_ready,   (owner == 1) && bus.mem_ready);
    end
    ready_seen[0] += int'(bus.i_ready);
    ready_seen[1] += int'(bus.d_ready);
  endtask

  task automatic update();
    if (owner >= 0) begin
      if (bus.mem_ready) begin
        cl[owner].act = 1'b0;
        owner = -1;
      end else begin
        memcnt--;
      end
    end else begin
      if (cl[1].act && !(cl[0].act && streak >= LIMIT)) begin
        owner  = 1;
        streak = cl[0].act ? ((streak < LIMIT) ? streak + 1 : streak) : 0;
      end else if (cl[0].act) begin
        owner  = 0;
        streak = 0;
      end
      if (owner >= 0) begin
        grants.push_back(owner);
        memcnt = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 4));
      end
    end
    for (int c = 0; c < 2; c++)
      if (!cl[c].act && int'($urandom_range(0, 99)) < gen_pct[c]) cl[c] = new_req();
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    check_cycle();
    update();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    owner     = -1;
    cl[0].act = 1'b0;
    cl[1].act = 1'b0;
    drive();
    #2;
    chk("rst_mem_read",  bus.mem_read,  0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_i_ready",   bus.i_ready,   0);
    chk("rst_d_ready",   bus.d_ready,   0);
    @(negedge clk);
    rst_n  = 1'b1;
    streak = 0;
    grants.delete();
    ready_seen[0] = 0;
    ready_seen[1] = 0;
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      cl[c]      = new_req();
      cl[c].act  = 1'b0;
      gen_pct[c] = 0;
    end
    drive();

    // Single icache read, memory completes on the third granted cycle
    do_reset();
    mem_lat = 2;
    cl[0].act = 1'b1; cl[0].rd = 1'b1; cl[0].wr = 1'b0; cl[0].addr = 28'h0000123;
    step();
    step();
    chk("s1_mem_read_n1", bus.mem_read, 1);
    chk("s1_mem_addr",    bus.mem_addr, 28'h0000123);
    for (int k = 0; k < 10 && ready_seen[0] == 0; k++) step();
    step();
    chk("s1_mem_read_after", bus.mem_read, 0);
    chk("s1_i_pulses", ready_seen[0], 1);
    chk("s1_d_pulses", ready_seen[1], 0);

    // mem_ready while idle with nobody requesting
    spur = 2;
    repeat (3) step();
    chk("s5_no_ready", ready_seen[0] + ready_seen[1], 1);
    spur = 0;

    // Both clients request in the same idle cycle
    do_reset();
    mem_lat = 2;
    cl[1].act = 1'b1; cl[1].rd = 1'b0; cl[1].wr = 1'b1; cl[1].addr = 28'h0000040;
    cl[1].wdata = 128'hCAFE_F00D_0123_4567_89AB_CDEF_5555_AAAA;
    cl[0].act = 1'b1; cl[0].rd = 1'b1; cl[0].wr = 1'b0; cl[0].addr = 28'h0000080;
    step();
    step();
    chk("s2_d_write", bus.mem_write, 1);
    chk("s2_d_addr",  bus.mem_addr,  28'h0000040);
    chk("s2_d_wdata", bus.mem_wdata, 128'hCAFE_F00D_0123_4567_89AB_CDEF_5555_AAAA);
    for (int k = 0; k < 30 && ready_seen[0] == 0; k++) step();
    chk("s2_n_grants", grants.size(), 2);
    chk("s2_first",  (grants.size() > 0) ? grants[0] : -1, 1);
    chk("s2_second", (grants.size() > 1) ? grants[1] : -1, 0);
`ifdef MEM_ARB_STAT_EN
    chk("s6_i_grants", i_grant_count, 1);
    chk("s6_d_grants", d_grant_count, 1);
    chk("s6_i_wait",   i_wait_cycles, 3 + 1);  // dcache held the port 3 cycles
    chk("s6_d_wait",   d_wait_cycles, 0);
`endif

    // dcache back-to-back while icache waits
    do_reset();
    mem_lat    = 1;
    gen_pct[1] = 100;
    cl[0] = new_req();
    cl[1] = new_req();
    for (int k = 0; k < 300 && grants.size() < 6; k++) step();
    chk("s3_n_grants", grants.size() >= 6, 1);
    for (int g = 0; g < 6; g++)
      chk($sformatf("s3_grant%0d", g), (grants.size() > g) ? grants[g] : -1, exp3[g]);
    gen_pct[1] = 0;

    // Reset in the middle of a dcache write; the held request is granted again
    do_reset();
    mem_lat = 20;
    cl[1] = new_req();
    cl[1].rd = 1'b0; cl[1].wr = 1'b1;
    step();
    step();
    chk("s4_pre_write", bus.mem_write, 1);
    @(posedge clk); #3;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("s4_rst_write", bus.mem_write, 0);
    chk("s4_rst_read",  bus.mem_read,  0);
    chk("s4_rst_addr",  bus.mem_addr,  0);
    chk("s4_rst_wdata", bus.mem_wdata, 0);
    chk("s4_rst_ready", bus.d_ready,   0);
    owner  = -1;
    streak = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cycle();
    update();
    step();
    chk("s4_regrant_write", bus.mem_write, 1);
    chk("s4_regrant_addr",  bus.mem_addr,  cl[1].addr);

    // Random traffic against the model
    mem_lat    = -1;
    spur       = 1;
    gen_pct[0] = 35;
    gen_pct[1] = 35;
    repeat (3000) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
